// File: rtl/ecc_secded_ram.sv
// SECDED-protected simple-dual-port RAM with read-path decode and error totals.
// Define ECC_ERR_INJECT_EN to build the read-path error injection counters.
module ecc_secded_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_ecc_error,
    output logic                  rd_ecc_uncorrectable,
    input  logic                  inj_load,
    input  logic [31:0]           inj_correctable_cnt,
    input  logic [31:0]           inj_uncorrectable_cnt,
    output logic [31:0]           err_correctable_total,
    output logic [31:0]           err_uncorrectable_total
);

    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((2 ** p) < dw + p + 1) p = p + 1;
        return p;
    endfunction

    localparam int P        = calc_p(DATA_WIDTH);
    localparam int CW_WIDTH = DATA_WIDTH + P + 1;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    typedef logic [CW_WIDTH-1:0] cw_t;

    localparam cw_t          CW_ONE = CW_WIDTH'(1);
    localparam logic [P:0]   CW_LIM = (P + 1)'(CW_WIDTH);

    // Bit i of the codeword is Hamming position i; bit 0 holds overall parity.
    function automatic cw_t group_mask(input int k);
        cw_t m;
        m = '0;
        for (int i = 1; i < CW_WIDTH; i++)
            if (((i >> k) & 1) == 1) m[i] = 1'b1;
        return m;
    endfunction

    function automatic cw_t encode(input logic [DATA_WIDTH-1:0] d);
        cw_t c;
        int  j;
        c = '0;
        j = 0;
        for (int i = 1; i < CW_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j = j + 1;
            end
        end
        for (int k = 0; k < P; k++) c[1 << k] = ^(c & group_mask(k));
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] gather(input cw_t c);
        logic [DATA_WIDTH-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i < CW_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = c[i];
                j = j + 1;
            end
        end
        return d;
    endfunction

    cw_t  mem [DEPTH];
    cw_t  rd_cw_q;
    logic s0_valid;
    cw_t  inj_mask;

    // Array and read register are deliberately outside reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= encode(wr_data);
        if (rd_en) rd_cw_q <= mem[rd_addr];
    end

`ifdef ECC_ERR_INJECT_EN
    logic        s0_addr_lsb;
    logic [31:0] inj_corr_q;
    logic [31:0] inj_unc_q;
    logic        inj_even;
    logic        inj_unc_hit;
    logic        inj_corr_hit;
    logic [31:0] inj_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid    <= 1'b0;
            s0_addr_lsb <= 1'b0;
        end else begin
            s0_valid    <= rd_en;
            s0_addr_lsb <= rd_addr[0];
        end
    end

    always_comb begin
        inj_even     = s0_valid && !s0_addr_lsb;
        inj_unc_hit  = inj_even && (inj_unc_q != 32'd0);
        inj_corr_hit = inj_even && (inj_unc_q == 32'd0)
                       && (inj_corr_q != 32'd0);
        inj_bit      = inj_corr_q % 32'(CW_WIDTH);
        inj_mask     = '0;
        if (inj_unc_hit)       inj_mask = CW_WIDTH'(3);
        else if (inj_corr_hit) inj_mask = CW_ONE << inj_bit;
    end

    // A load in the same cycle as an injecting read discards its decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_corr_q <= 32'd0;
            inj_unc_q  <= 32'd0;
        end else if (inj_load) begin
            inj_corr_q <= inj_correctable_cnt;
            inj_unc_q  <= inj_uncorrectable_cnt;
        end else begin
            if (inj_unc_hit)  inj_unc_q  <= inj_unc_q - 32'd1;
            if (inj_corr_hit) inj_corr_q <= inj_corr_q - 32'd1;
        end
    end
`else
    logic unused_inj;

    assign unused_inj = ^{inj_load, inj_correctable_cnt,
                          inj_uncorrectable_cnt};
    assign inj_mask   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s0_valid <= 1'b0;
        else     s0_valid <= rd_en;
    end
`endif

    cw_t                   cw_s1;
    cw_t                   fix_mask;
    logic [P-1:0]          syn;
    logic                  pe;
    logic                  in_range;
    logic                  single_err;
    logic                  double_err;
    logic [DATA_WIDTH-1:0] data_s1;

    always_comb begin
        cw_s1 = rd_cw_q ^ inj_mask;
        syn   = '0;
        for (int k = 0; k < P; k++) syn[k] = ^(cw_s1 & group_mask(k));
        pe         = ^cw_s1;
        in_range   = {1'b0, syn} < CW_LIM;
        single_err = pe && in_range;
        double_err = (pe && !in_range) || (!pe && (syn != '0));
        fix_mask   = single_err ? (CW_ONE << syn) : '0;
        data_s1    = gather(cw_s1 ^ fix_mask);
    end

    logic [31:0] corr_total_q;
    logic [31:0] unc_total_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid             <= 1'b0;
            rd_data              <= '0;
            rd_ecc_error         <= 1'b0;
            rd_ecc_uncorrectable <= 1'b0;
            corr_total_q         <= 32'd0;
            unc_total_q          <= 32'd0;
        end else begin
            rd_valid <= s0_valid;
            if (s0_valid) begin
                rd_data              <= data_s1;
                rd_ecc_error         <= single_err || double_err;
                rd_ecc_uncorrectable <= double_err;
                if (single_err && (corr_total_q != 32'hFFFF_FFFF))
                    corr_total_q <= corr_total_q + 32'd1;
                if (double_err && (unc_total_q != 32'hFFFF_FFFF))
                    unc_total_q <= unc_total_q + 32'd1;
            end
        end
    end

    assign err_correctable_total   = corr_total_q;
    assign err_uncorrectable_total = unc_total_q;

endmodule

// File: tb/tb_ecc_secded_ram.sv
// Randomised bench for ecc_secded_ram against a word-level reference model.
// Decode paths are exercised by overriding the stage-0 codeword register.
`timescale 1ns/1ps
module tb_ecc_secded_ram;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int PB = 6;
    localparam int CW = 39;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ecc_error;
    logic          rd_ecc_uncorrectable;
    logic          inj_load = 1'b0;
    logic [31:0]   inj_correctable_cnt = '0;
    logic [31:0]   inj_uncorrectable_cnt = '0;
    logic [31:0]   err_correctable_total;
    logic [31:0]   err_uncorrectable_total;

    ecc_secded_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .wr_en                   (wr_en),
        .wr_addr                 (wr_addr),
        .wr_data                 (wr_data),
        .rd_en                   (rd_en),
        .rd_addr                 (rd_addr),
        .rd_valid                (rd_valid),
        .rd_data                 (rd_data),
        .rd_ecc_error            (rd_ecc_error),
        .rd_ecc_uncorrectable    (rd_ecc_uncorrectable),
        .inj_load                (inj_load),
        .inj_correctable_cnt     (inj_correctable_cnt),
        .inj_uncorrectable_cnt   (inj_uncorrectable_cnt),
        .err_correctable_total   (err_correctable_total),
        .err_uncorrectable_total (err_uncorrectable_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          err;
        logic          unc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mdl [0:(1<<AW)-1];
    logic [31:0]   m_corr = '0;
    logic [31:0]   m_unc = '0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [CW-1:0] force_cw;
    exp_t          ce;
    logic          cv;
`ifdef ECC_ERR_INJECT_EN
    int unsigned   m_icc = 0;
    int unsigned   m_iuc = 0;
`endif

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit is_pow2(input int v);
        return (v & (v - 1)) == 0;
    endfunction

    // Textbook Hamming: data fills non-power-of-two positions in order,
    // parity k covers every position whose index has bit k set.
    function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++)
            if (!is_pow2(pos)) begin
                c[pos] = d[j];
                j++;
            end
        for (int k = 0; k < PB; k++) begin
            logic b;
            b = 1'b0;
            for (int pos = 1; pos < CW; pos++)
                if ((pos & (1 << k)) != 0) b = b ^ c[pos];
            c[1 << k] = b;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [DW-1:0] m_extract(input logic [CW-1:0] c);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++)
            if (!is_pow2(pos)) begin
                d[j] = c[pos];
                j++;
            end
        return d;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                ce = q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL read_lost: no rd_valid at cycle %0d", ce.due);
            end
            cv = (q.size() > 0) && (q[0].due == cyc);
            chk("rd_valid", 64'(rd_valid), 64'(cv));
            if (cv) begin
                ce = q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(ce.data));
                chk("rd_ecc_error", 64'(rd_ecc_error), 64'(ce.err));
                chk("rd_ecc_unc", 64'(rd_ecc_uncorrectable), 64'(ce.unc));
                if (ce.err && !ce.unc && m_corr != 32'hFFFF_FFFF) m_corr++;
                if (ce.unc && m_unc != 32'hFFFF_FFFF) m_unc++;
            end
            chk("corr_total", 64'(err_correctable_total), 64'(m_corr));
            chk("unc_total", 64'(err_uncorrectable_total), 64'(m_unc));
        end
    end

    task automatic push_read(input logic [AW-1:0] ra);
        exp_t e;
        e.due  = cyc + 2;
        e.data = mdl[ra];
        e.err  = 1'b0;
        e.unc  = 1'b0;
`ifdef ECC_ERR_INJECT_EN
        if (ra[0] == 1'b0) begin
            if (m_iuc > 0) begin
                e.err = 1'b1;
                e.unc = 1'b1;
                m_iuc--;
            end else if (m_icc > 0) begin
                e.err = 1'b1;
                m_icc--;
            end
        end
`endif
        q.push_back(e);
    endtask

    task automatic cycle_op(input logic we, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic re,
                            input logic [AW-1:0] ra);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (re) push_read(ra);
        if (we) mdl[wa] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_op(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic forced_read(input logic [AW-1:0] a, input logic [CW-1:0] cw,
                               input logic [DW-1:0] d, input logic err,
                               input logic unc);
        exp_t e;
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b1;
        rd_addr = a;
        e.due   = cyc + 2;
        e.data  = d;
        e.err   = err;
        e.unc   = unc;
        q.push_back(e);
        @(negedge clk);
        rd_en    = 1'b0;
        force_cw = cw;
        force dut.rd_cw_q = force_cw;
        @(negedge clk);
        release dut.rd_cw_q;
    endtask

    task automatic load_inj(input logic [31:0] cc, input logic [31:0] uc);
        @(negedge clk);
        inj_load              = 1'b1;
        inj_correctable_cnt   = cc;
        inj_uncorrectable_cnt = uc;
`ifdef ECC_ERR_INJECT_EN
        m_icc = cc;
        m_iuc = uc;
`endif
        @(negedge clk);
        inj_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int            b1;
        int            b2;

        chk("enc_pin_0", 64'(m_encode(32'h0)), 64'h0);
        chk("enc_pin_1", 64'(m_encode(32'h1)), 64'hF);
        chk("enc_pin_2", 64'(m_encode(32'h2)), 64'h33);

        repeat (2) @(negedge clk);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_err", 64'(rd_ecc_error), 64'h0);
        chk("rst_unc", 64'(rd_ecc_uncorrectable), 64'h0);
        chk("rst_corr_tot", 64'(err_correctable_total), 64'h0);
        chk("rst_unc_tot", 64'(err_uncorrectable_total), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 512; i++)
            cycle_op(1'b1, AW'(i), 32'(i) * 32'h0101_0101, 1'b0, '0);
        for (int i = 0; i < 512; i++)
            cycle_op(1'b0, '0, '0, 1'b1, AW'(i));
        idle(4);

        for (int i = 0; i < 1500; i++)
            cycle_op(1'($urandom_range(0, 1)), AW'($urandom),
                     32'($urandom), 1'($urandom_range(0, 1)), AW'($urandom));
        idle(4);

        cycle_op(1'b1, 9'd5, 32'hAAAA_AAAA, 1'b0, '0);
        cycle_op(1'b1, 9'd5, 32'h5555_5555, 1'b1, 9'd5);
        cycle_op(1'b0, '0, '0, 1'b1, 9'd5);
        idle(4);

        for (int pos = 0; pos < CW; pos++) begin
            a = AW'($urandom);
            c = m_encode(mdl[a]) ^ (CW'(1) << pos);
            forced_read(a, c, mdl[a], 1'b1, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            a  = AW'($urandom);
            b1 = int'($urandom_range(0, CW - 1));
            b2 = (b1 + int'($urandom_range(1, CW - 1))) % CW;
            c  = m_encode(mdl[a]) ^ (CW'(1) << b1) ^ (CW'(1) << b2);
            forced_read(a, c, m_extract(c), 1'b1, 1'b1);
        end
        a = 9'd12;
        c = m_encode(mdl[a]) ^ CW'(39'h01_0000_0102);
        forced_read(a, c, mdl[a], 1'b1, 1'b1);
        d = 32'hCAFE_F00D;
        forced_read(9'd13, m_encode(d), d, 1'b0, 1'b0);
        idle(4);

        cycle_op(1'b1, 9'd7, 32'h1234_5678, 1'b0, '0);
        idle(2);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = 9'd7;
        @(posedge clk);
        #1 rst = 1'b1;
        rd_en = 1'b0;
        q.delete();
        m_corr = '0;
        m_unc  = '0;
`ifdef ECC_ERR_INJECT_EN
        m_icc = 0;
        m_iuc = 0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_drop_valid", 64'(rd_valid), 64'h0);
        chk("rst_corr_zero", 64'(err_correctable_total), 64'h0);
        cycle_op(1'b0, '0, '0, 1'b1, 9'd7);
        idle(4);
        chk("word7_kept", 64'(mdl[7]), 64'h1234_5678);

        load_inj(32'd100, 32'd0);
        for (int i = 0; i < 512; i++)
            cycle_op(1'b0, '0, '0, 1'b1, AW'(i));
        idle(4);
`ifdef ECC_ERR_INJECT_EN
        chk("inj_corr_total", 64'(err_correctable_total), 64'd100);
        load_inj(32'd0, 32'd100);
        for (int i = 0; i < 512; i++)
            cycle_op(1'b0, '0, '0, 1'b1, AW'(i));
        idle(4);
        chk("inj_unc_total", 64'(err_uncorrectable_total), 64'd100);
        load_inj(32'd0, 32'd0);
`else
        chk("noinj_corr_total", 64'(err_correctable_total), 64'd0);
        chk("noinj_unc_total", 64'(err_uncorrectable_total), 64'd0);
`endif

        @(negedge clk);
        #2 force dut.corr_total_q = 32'hFFFF_FFFE;
        #1 release dut.corr_total_q;
        m_corr = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            a = AW'($urandom);
            c = m_encode(mdl[a]) ^ (CW'(1) << (i * 7 + 2));
            forced_read(a, c, mdl[a], 1'b1, 1'b0);
        end
        idle(4);
        chk("sat_corr_total", 64'(err_correctable_total), 64'hFFFF_FFFF);

        idle(2);
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d reads outstanding, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
